// File: rtl/x_mem_rsp.sv
// Memory-side responder for the core's valid/accept bus: word RAM plus a small
// peripheral block (GPIO, free-running cycle counter, sticky unmapped-access flag).
module x_mem_rsp #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  output logic [31:0] o_gpio,
  output logic        o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [29:0] GPIO_WA = 30'h2000_0000;
  localparam logic [29:0] CTR_WA  = 30'h2000_0001;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SEL_RAM, SEL_GPIO, SEL_CTR, SEL_NONE} sel_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        req_rnw;
  logic [29:0] req_wa;
  logic [31:0] req_data;
  logic [29:0] eff_wa;
  sel_t        sel;
  logic [31:0] rd_val;
  logic [31:0] cycle_cnt;
  logic [31:0] ram [DEPTH];
  logic        unused_addr_bits;

  // Byte lane bits carry no meaning on a word-only bus.
  assign unused_addr_bits = ^i_addr[1:0];

  // With LATENCY=1 the request is captured on the same edge that enters RESP,
  // so the read path must look at the live bus while still in IDLE.
  assign eff_wa = (state == IDLE) ? i_addr[31:2] : req_wa;

  always_comb begin
    if (eff_wa[29:26] == 4'h0)  sel = SEL_RAM;
    else if (eff_wa == GPIO_WA) sel = SEL_GPIO;
    else if (eff_wa == CTR_WA)  sel = SEL_CTR;
    else                        sel = SEL_NONE;
  end

  always_comb begin
    case (sel)
      SEL_RAM:  rd_val = ram[eff_wa[AW-1:0]];
      SEL_GPIO: rd_val = o_gpio;
      SEL_CTR:  rd_val = cycle_cnt;
      default:  rd_val = '0;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 32'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 32'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_accept = (state == RESP);

  // NOTE: registers update with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_rnw   <= 1'b1;
      req_wa    <= '0;
      req_data  <= '0;
      o_data    <= '0;
      o_gpio    <= '0;
      o_err     <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state == IDLE && i_valid) begin
        req_rnw  <= i_rnw;
        req_wa   <= i_addr[31:2];
        req_data <= i_data;
      end
      o_data <= (state_nxt == RESP) ? rd_val : '0;
      if (state == RESP) begin
        if (!req_rnw && sel == SEL_GPIO) o_gpio <= req_data;
        if (sel == SEL_NONE)             o_err  <= 1'b1;
      end
    end
  end

  // NOTE: the RAM array has no reset; only the write enable sees i_rst, so a
  // reset in RESP still suppresses the commit.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == RESP && !req_rnw && sel == SEL_RAM)
      ram[req_wa[AW-1:0]] <= req_data;
  end

endmodule
